// File: rtl/stacker_pkg.sv
// stacker_pkg: widths, chunk record and lane-mask helper shared by the
// pixel-to-chunk stacker and its output register.
package stacker_pkg;

    localparam int PIXEL_W       = 8;
    localparam int CHUNK_W       = 128;
    localparam int PIX_PER_CHUNK = 16;
    localparam int LANE_IDX_W    = 4;

    // One packed chunk as it travels through the output register
    typedef struct packed {
        logic [CHUNK_W-1:0]       data;
        logic                     last;
        logic [PIX_PER_CHUNK-1:0] keep;
    } chunk_t;

    // Low-contiguous mask with lanes 0..lastLane set
    function automatic logic [PIX_PER_CHUNK-1:0] laneMask(input logic [LANE_IDX_W-1:0] lastLane);
        logic [PIX_PER_CHUNK-1:0] mask;
        mask = '0;
        for (int k = 0; k < PIX_PER_CHUNK; k++) begin
            if (k <= int'(lastLane)) begin
                mask[k] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/stacker_axis_out_reg.sv
// axis_out_reg: one-entry AXI-Stream output register. A loaded chunk is held
// stable until the consumer takes it; a load in the same cycle as a transfer
// replaces the entry without a bubble.
module axis_out_reg
    import stacker_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_load,
    input  chunk_t i_chunk,
    input  logic   i_ready,
    output logic   o_valid,
    output chunk_t o_chunk
);

    logic   r_valid;
    chunk_t r_chunk;

    // Take a new chunk when loaded, otherwise empty the entry once it drains
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_chunk <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_chunk <= i_chunk;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_chunk = r_chunk;

endmodule

// File: rtl/stacker.sv
// stacker: packs 16 accepted 8-bit pixels (or fewer, closed by pixel_tlast)
// into one 128-bit chunk, lane 0 holding the first pixel.
// Optional macro STACKER_TKEEP_EN adds output chunk_tkeep (lane-valid mask).
module stacker
    import stacker_pkg::*;
#(
    parameter logic [PIXEL_W-1:0] PAD_BYTE = 8'h00
)
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               pixel_tvalid,
    output logic               pixel_tready,
    input  logic [PIXEL_W-1:0] pixel_tdata,
    input  logic               pixel_tlast,
    output logic               chunk_tvalid,
    input  logic               chunk_tready,
    output logic [CHUNK_W-1:0] chunk_tdata,
    output logic               chunk_tlast
`ifdef STACKER_TKEEP_EN
    ,
    output logic [PIX_PER_CHUNK-1:0] chunk_tkeep
`endif
);

    logic [LANE_IDX_W-1:0] r_laneCount;
    logic [CHUNK_W-1:0]    r_accum;
    logic                  r_active;

    logic   w_accept;
    logic   w_complete;
    logic   w_outValid;
    chunk_t w_newChunk;
    chunk_t w_outChunk;

    // Ready only depends on the output register, and stays low until the
    // first clock edge after reset release.
    assign pixel_tready = r_active && (!w_outValid || chunk_tready);
    assign w_accept     = pixel_tvalid && pixel_tready;
    assign w_complete   = w_accept &&
                          (pixel_tlast || (r_laneCount == LANE_IDX_W'(PIX_PER_CHUNK - 1)));

    // Arms the input side one edge after reset is released
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Lane counter and accumulator; a completed chunk leaves a padded, empty accumulator
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_laneCount <= '0;
            r_accum     <= {PIX_PER_CHUNK{PAD_BYTE}};
        end else if (w_accept) begin
            if (w_complete) begin
                r_laneCount <= '0;
                r_accum     <= {PIX_PER_CHUNK{PAD_BYTE}};
            end else begin
                r_accum[{r_laneCount, 3'b000} +: PIXEL_W] <= pixel_tdata;
                r_laneCount <= r_laneCount + LANE_IDX_W'(1);
            end
        end
    end

    // Outgoing chunk: accumulator with the completing pixel merged into its lane
    always_comb begin
        w_newChunk      = '0;
        w_newChunk.data = r_accum;
        w_newChunk.data[{r_laneCount, 3'b000} +: PIXEL_W] = pixel_tdata;
        w_newChunk.last = pixel_tlast;
`ifdef STACKER_TKEEP_EN
        w_newChunk.keep = laneMask(r_laneCount);
`endif
    end

    axis_out_reg u_outReg (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_load  (w_complete),
        .i_chunk (w_newChunk),
        .i_ready (chunk_tready),
        .o_valid (w_outValid),
        .o_chunk (w_outChunk)
    );

    assign chunk_tvalid = w_outValid;
    assign chunk_tdata  = w_outChunk.data;
    assign chunk_tlast  = w_outChunk.last;

`ifdef STACKER_TKEEP_EN
    assign chunk_tkeep = w_outChunk.keep;
`else
    logic [PIX_PER_CHUNK-1:0] w_unusedKeep;
    assign w_unusedKeep = w_outChunk.keep;
`endif

endmodule

// File: tb/tb_stacker.sv
// tb_stacker: directed and randomised stimulus for stacker, checked against a
// queue-based packing model. Define STACKER_TKEEP_EN to also check chunk_tkeep.
module tb_stacker;

    localparam logic [7:0] TB_PAD = 8'hEE;

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [15:0]  keep;
    } expChunk_t;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         pixel_tvalid;
    logic         pixel_tready;
    logic [7:0]   pixel_tdata;
    logic         pixel_tlast;
    logic         chunk_tvalid;
    logic         chunk_tready;
    logic [127:0] chunk_tdata;
    logic         chunk_tlast;
`ifdef STACKER_TKEEP_EN
    logic [15:0]  chunk_tkeep;
    logic [15:0]  lastKeep;
`endif

    int           totalChecks = 0;
    int           badChecks = 0;
    int           cycleCount = 0;
    int           chunkCount = 0;
    int           readyLowCount = 0;
    bit           phaseBackToBack = 0;
    bit           randomReady = 0;
    bit           readyAllowed;
    bit           holdPending = 0;
    bit           expectValidNext = 0;
    logic [127:0] heldData;
    logic         heldLast;
    logic [127:0] lastData = '0;
    logic         lastLast = 1'b0;
    logic [7:0]   partData[$];
    expChunk_t    expQ[$];
    expChunk_t    popped;
    int           tCycles[$];

    // Free-running clock
    always #5 clk_in = ~clk_in;

    stacker #(.PAD_BYTE(TB_PAD)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .pixel_tvalid (pixel_tvalid),
        .pixel_tready (pixel_tready),
        .pixel_tdata  (pixel_tdata),
        .pixel_tlast  (pixel_tlast),
        .chunk_tvalid (chunk_tvalid),
        .chunk_tready (chunk_tready),
        .chunk_tdata  (chunk_tdata),
        .chunk_tlast  (chunk_tlast)
`ifdef STACKER_TKEEP_EN
        ,
        .chunk_tkeep  (chunk_tkeep)
`endif
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        totalChecks++;
        badChecks++;
        $display("[TB] FAIL %s: timed out waiting, required the event within its cycle budget", name);
    endtask

    // Packing rule: collect accepted bytes until 16 or tlast, pad the rest
    task automatic modelAccept(input logic [7:0] d, input logic l);
        expChunk_t c;
        partData.push_back(d);
        if (l || partData.size() == 16) begin
            c.data = {16{TB_PAD}};
            for (int i = 0; i < partData.size(); i++) begin
                c.data[8*i +: 8] = partData[i];
            end
            c.last = l;
            c.keep = 16'((33'd1 << partData.size()) - 33'd1);
            expQ.push_back(c);
            partData.delete();
            expectValidNext = 1;
        end
    endtask

    // Cycle counter for transfer timing
    always @(posedge clk_in) cycleCount <= cycleCount + 1;

    // Input side may only open from the first edge after reset release
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) readyAllowed <= 1'b0;
        else           readyAllowed <= 1'b1;
    end

    // Randomised consumer backpressure during the soak phase
    always @(posedge clk_in) begin
        #2;
        if (randomReady) chunk_tready = 1'($urandom_range(0, 1));
    end

    // Compare process: samples every falling edge, ahead of the next rising edge
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            checkOutput("resetValid", 128'(chunk_tvalid), 128'd0);
            checkOutput("resetData", chunk_tdata, 128'd0);
            checkOutput("resetLast", 128'(chunk_tlast), 128'd0);
            checkOutput("resetReady", 128'(pixel_tready), 128'd0);
`ifdef STACKER_TKEEP_EN
            checkOutput("resetKeep", 128'(chunk_tkeep), 128'd0);
`endif
            partData.delete();
            expQ.delete();
            holdPending = 0;
            expectValidNext = 0;
        end else begin
            if (expectValidNext) checkOutput("latencyValid", 128'(chunk_tvalid), 128'd1);
            expectValidNext = 0;
            if (!readyAllowed) checkOutput("readyBeforeEdge", 128'(pixel_tready), 128'd0);
            else checkOutput("readyRule", 128'(pixel_tready), 128'(!chunk_tvalid || chunk_tready));
            if (holdPending) begin
                checkOutput("holdValid", 128'(chunk_tvalid), 128'd1);
                checkOutput("holdData", chunk_tdata, heldData);
                checkOutput("holdLast", 128'(chunk_tlast), 128'(heldLast));
            end
            holdPending = chunk_tvalid && !chunk_tready;
            heldData = chunk_tdata;
            heldLast = chunk_tlast;
            if (chunk_tvalid && chunk_tready) begin
                chunkCount++;
                tCycles.push_back(cycleCount);
                lastData = chunk_tdata;
                lastLast = chunk_tlast;
`ifdef STACKER_TKEEP_EN
                lastKeep = chunk_tkeep;
`endif
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedChunk", chunk_tdata, 128'hx);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("chunkData", chunk_tdata, popped.data);
                    checkOutput("chunkLast", 128'(chunk_tlast), 128'(popped.last));
`ifdef STACKER_TKEEP_EN
                    checkOutput("chunkKeep", 128'(chunk_tkeep), 128'(popped.keep));
`endif
                end
            end
            if (phaseBackToBack && !pixel_tready) readyLowCount++;
            if (pixel_tvalid && pixel_tready) modelAccept(pixel_tdata, pixel_tlast);
        end
    end

    // Offer one pixel and hold it until accepted
    task automatic applyStimulus(input logic [7:0] d, input logic l);
        int waited;
        bit done;
        pixel_tvalid = 1'b1;
        pixel_tdata  = d;
        pixel_tlast  = l;
        waited = 0;
        done = 0;
        while (!done && waited < 200) begin
            @(negedge clk_in);
            done = pixel_tready;
            @(posedge clk_in);
            #2;
            waited++;
        end
        if (!done) timeoutFail("pixelAccept");
    endtask

    task automatic idle(input int n);
        pixel_tvalid = 1'b0;
        pixel_tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        int waited;
        waited = 0;
        while ((expQ.size() != 0 || chunk_tvalid) && waited < maxCycles) begin
            @(posedge clk_in);
            #2;
            waited++;
        end
        if (expQ.size() != 0 || chunk_tvalid) timeoutFail("drain");
    endtask

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence followed by a randomised soak
    initial begin
        int base;
        int idx;
        bit accepted;
        bit afterChecked;
        logic l;

        rst_n_in     = 1'b0;
        pixel_tvalid = 1'b0;
        pixel_tdata  = 8'h00;
        pixel_tlast  = 1'b0;
        chunk_tready = 1'b1;
        repeat (3) @(posedge clk_in);
        #3 rst_n_in = 1'b1;
        @(posedge clk_in);
        #2;

        $display("[TB] full chunk 00..0F");
        base = chunkCount;
        for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0);
        idle(1);
        waitDrain(50);
        checkOutput("fullCount", 128'(chunkCount - base), 128'd1);
        checkOutput("fullData", lastData, 128'h0F0E0D0C0B0A09080706050403020100);
        checkOutput("fullLast", 128'(lastLast), 128'd0);
`ifdef STACKER_TKEEP_EN
        checkOutput("fullKeep", 128'(lastKeep), 128'h0000FFFF);
`endif

        $display("[TB] partial chunk A0..A4 and single pixel 55");
        base = chunkCount;
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'hA0 + i), (i == 4));
        idle(1);
        waitDrain(50);
        checkOutput("partCount", 128'(chunkCount - base), 128'd1);
        checkOutput("partData", lastData, 128'hEEEEEEEEEEEEEEEEEEEEEEA4A3A2A1A0);
        checkOutput("partLast", 128'(lastLast), 128'd1);
`ifdef STACKER_TKEEP_EN
        checkOutput("partKeep", 128'(lastKeep), 128'h001F);
`endif
        applyStimulus(8'h55, 1'b1);
        idle(1);
        waitDrain(50);
        checkOutput("singleData", lastData, 128'hEEEEEEEEEEEEEEEEEEEEEEEEEEEEEE55);
        checkOutput("singleLast", 128'(lastLast), 128'd1);
`ifdef STACKER_TKEEP_EN
        checkOutput("singleKeep", 128'(lastKeep), 128'h0001);
`endif

        $display("[TB] tlast on lane 15");
        base = chunkCount;
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'h60 + i), (i == 15));
        idle(3);
        waitDrain(50);
        checkOutput("lane15Count", 128'(chunkCount - base), 128'd1);
        checkOutput("lane15Data", lastData, 128'h6F6E6D6C6B6A69686766656463626160);
        checkOutput("lane15Last", 128'(lastLast), 128'd1);

        $display("[TB] 64 pixels back to back");
        base = chunkCount;
        tCycles.delete();
        readyLowCount = 0;
        phaseBackToBack = 1;
        for (int i = 0; i < 64; i++) applyStimulus(8'(i), 1'b0);
        phaseBackToBack = 0;
        idle(1);
        waitDrain(50);
        checkOutput("b2bCount", 128'(chunkCount - base), 128'd4);
        checkOutput("b2bReadyLow", 128'(readyLowCount), 128'd0);
        if (tCycles.size() >= 4) begin
            for (int k = 1; k < 4; k++) checkOutput("b2bSpacing", 128'(tCycles[k] - tCycles[k-1]), 128'd16);
        end else begin
            checkOutput("b2bTransfers", 128'(tCycles.size()), 128'd4);
        end

        $display("[TB] stalled consumer for 20 cycles");
        chunk_tready = 1'b0;
        base = chunkCount;
        idx = 0;
        afterChecked = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            pixel_tvalid = 1'b1;
            pixel_tdata  = 8'(8'h40 + idx);
            pixel_tlast  = 1'b0;
            @(negedge clk_in);
            accepted = pixel_tready;
            if (idx == 16 && !afterChecked) begin
                checkOutput("stallReadyLow", 128'(pixel_tready), 128'd0);
                afterChecked = 1;
            end
            @(posedge clk_in);
            #2;
            if (accepted) idx++;
        end
        checkOutput("stallAccepted", 128'(idx), 128'd16);
        checkOutput("stallNoTransfer", 128'(chunkCount - base), 128'd0);
        chunk_tready = 1'b1;
        while (idx < 32) begin
            applyStimulus(8'(8'h40 + idx), 1'b0);
            idx++;
        end
        idle(1);
        waitDrain(50);
        checkOutput("stallCount", 128'(chunkCount - base), 128'd2);
        checkOutput("stallChunk2", lastData, 128'h5F5E5D5C5B5A59585756555453525150);

        $display("[TB] reset in the middle of a chunk");
        for (int i = 0; i < 7; i++) applyStimulus(8'(8'h30 + i), 1'b0);
        idle(1);
        @(posedge clk_in);
        #3 rst_n_in = 1'b0;
        @(posedge clk_in);
        #3 rst_n_in = 1'b1;
        @(posedge clk_in);
        #2;
        base = chunkCount;
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'h10 + i), 1'b0);
        idle(1);
        waitDrain(50);
        checkOutput("rstCount", 128'(chunkCount - base), 128'd1);
        checkOutput("rstData", lastData, 128'h1F1E1D1C1B1A19181716151413121110);
        checkOutput("rstLane0", 128'(lastData[7:0]), 128'h10);
        checkOutput("rstLast", 128'(lastLast), 128'd0);

        $display("[TB] random soak, 1000 pixels");
        randomReady = 1;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            l = (n == 999) ? 1'b1 : ($urandom_range(0, 7) == 0);
            applyStimulus(8'($urandom_range(0, 255)), l);
        end
        idle(1);
        randomReady = 0;
        @(posedge clk_in);
        #3 chunk_tready = 1'b1;
        waitDrain(100);
        checkOutput("soakQueueEmpty", 128'(expQ.size()), 128'd0);
        checkOutput("soakPartialEmpty", 128'(partData.size()), 128'd0);

        idle(2);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
